led_matrix_scanner: RTL and testbench

Parametrised successor to the 8x8 LED matrix driver. It takes a full ROWS x COLS frame through a ready/valid load port into a shadow buffer and swaps the shadow into the active buffer only at frame boundaries, so the display never tears. It then multiplexes the active frame onto row cathodes and column anodes. It supports per-pixel or whole-row scan, programmable dwell, PWM brightness and blanking, and sits between the game logic and the matrix pins.

---
 rtl/led_matrix_scanner_if.sv | 19 +
 rtl/led_matrix_scanner.sv | 163 ++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_scanner_if.sv
// rtl/led_matrix_scanner_if.sv - frame load port for led_matrix_scanner
//
// Carries one full ROWS x COLS frame per accepted transfer.
//   frame_in    : row r at bits [r*COLS +: COLS], bit COLS-1 of a row = leftmost column
//   frame_valid : producer has a frame on frame_in
//   frame_ready : consumer shadow buffer is free; transfer fires on valid && ready
// master = frame producer (game logic), slave = scanner.

interface led_matrix_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic [ROWS*COLS-1:0] frame_in;
    logic                 frame_valid;
    logic                 frame_ready;

    modport master (output frame_in, output frame_valid, input frame_ready);
    modport slave  (input frame_in, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - double-buffered multiplexed LED matrix scanner
//
// Accepts whole frames into a shadow buffer and swaps them into the active
// buffer only at frame boundaries, then scans the active frame onto the
// matrix pins either one pixel or one row per slot, with per-slot PWM dwell.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   load        : frame load port (slave side of led_matrix_scanner_if)
//   row_mode    : 0 = pixel scan, 1 = row scan; taken at frame boundary only
//   brightness  : PWM duty code, sampled every cycle
//   blank       : force display dark from the next cycle; scan keeps running
//   out_cathode : active-low row select, row 0 on the MSB
//   out_anode   : active-high column drive
//   frame_start : one-cycle pulse on the first output cycle of each frame

module led_matrix_scanner #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int DWELL    = 1,
    parameter int BRIGHT_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    led_matrix_scanner_if.slave load,
    input  logic                row_mode,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic                blank,
    output logic [ROWS-1:0]     out_cathode,
    output logic [COLS-1:0]     out_anode,
    output logic                frame_start
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PW = $clog2(DWELL) + BRIGHT_W + 1;

    logic [ROWS-1:0][COLS-1:0] shadow_q, shadow_d;
    logic [ROWS-1:0][COLS-1:0] active_q, active_d;
    logic                      pending_q, pending_d;
    logic                      mode_q, mode_d;
    logic [RW-1:0]             r_q, r_d;
    logic [CW-1:0]             c_q, c_d;
    logic [DW-1:0]             d_q, d_d;
    logic [ROWS-1:0]           cathode_q, cathode_d;
    logic [COLS-1:0]           anode_q, anode_d;
    logic                      frame_start_q, frame_start_d;

    logic                      slot_end;
    logic                      row_end;
    logic                      boundary;
    logic                      load_fire;
    logic [PW-1:0]             on_cycles;
    logic [COLS-1:0]           row_bits;

    // Slot / row / frame completion, all judged on the current counter state.
    always_comb begin
        slot_end  = (d_q == DW'(DWELL - 1));
        row_end   = slot_end && (mode_q || (c_q == '0));
        boundary  = row_end && (r_q == RW'(ROWS - 1));
        load_fire = load.frame_valid && !pending_q;
    end

    // Registered flag only: no path from frame_valid to frame_ready.
    assign load.frame_ready = !pending_q;

    // Double buffer. A load can only fire with pending clear, so a load that
    // coincides with a boundary fills the shadow but leaves active alone.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        mode_d    = mode_q;
        if (load_fire) begin
            shadow_d = load.frame_in;
        end
        if (boundary) begin
            mode_d = row_mode;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
        if (load_fire) begin
            pending_d = 1'b1;
        end
    end

    // Scan counters: dwell innermost, then column (pixel mode only), then row.
    // In row mode the column counter simply rests at COLS-1.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        d_d = d_q;
        if (!slot_end) begin
            d_d = d_q + 1'b1;
        end else begin
            d_d = '0;
            if (row_end) begin
                c_d = CW'(COLS - 1);
                r_d = (r_q == RW'(ROWS - 1)) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q - 1'b1;
            end
        end
    end

    // Pin values for the slot the counters point at; registered below so the
    // pins lag the counters by exactly one cycle.
    always_comb begin
        on_cycles = ((PW'(brightness) + PW'(1)) * PW'(DWELL)) >> BRIGHT_W;
        row_bits  = active_q[r_q];
        cathode_d = '1;
        anode_d   = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i == ROWS - 1 - int'(r_q)) begin
                cathode_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < COLS; i++) begin
            anode_d[i] = row_bits[i] && (mode_q || (i == int'(c_q)));
        end
        if (blank || (PW'(d_q) >= on_cycles)) begin
            anode_d = '0;
        end
        if (blank) begin
            cathode_d = '1;
        end
        frame_start_d = (r_q == '0) && (c_q == CW'(COLS - 1)) && (d_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            mode_q        <= 1'b0;
            r_q           <= '0;
            c_q           <= CW'(COLS - 1);
            d_q           <= '0;
            cathode_q     <= '1;
            anode_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            mode_q        <= mode_d;
            r_q           <= r_d;
            c_q           <= c_d;
            d_q           <= d_d;
            cathode_q     <= cathode_d;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out_cathode = cathode_q;
    assign out_anode   = anode_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - directed self-checking bench for led_matrix_scanner

module tb_led_matrix_scanner;
    logic       clk = 1'b0;
    logic       reset;
    logic       row_mode, blank, row_mode2, blank2;
    logic [2:0] brightness, brightness2;
    logic [7:0] cath1, an1, cath2, an2;
    logic       fs1, fs2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    led_matrix_scanner_if #(.ROWS(8), .COLS(8)) lif1 ();
    led_matrix_scanner_if #(.ROWS(8), .COLS(8)) lif2 ();

    led_matrix_scanner #(.ROWS(8), .COLS(8), .DWELL(1), .BRIGHT_W(3)) dut (
        .clk(clk), .reset(reset), .load(lif1), .row_mode(row_mode),
        .brightness(brightness), .blank(blank),
        .out_cathode(cath1), .out_anode(an1), .frame_start(fs1)
    );

    led_matrix_scanner #(.ROWS(8), .COLS(8), .DWELL(8), .BRIGHT_W(3)) dut_pwm (
        .clk(clk), .reset(reset), .load(lif2), .row_mode(row_mode2),
        .brightness(brightness2), .blank(blank2),
        .out_cathode(cath2), .out_anode(an2), .frame_start(fs2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs1();
        int n = 0;
        do begin
            tick();
            n++;
        end while (fs1 !== 1'b1 && n < 200);
        total++;
        if (fs1 !== 1'b1) begin
            bad++;
            $display("FAIL wait_fs1: frame_start=%b after %0d cycles, want 1", fs1, n);
        end
    endtask

    task automatic wait_fs2();
        int n = 0;
        do begin
            tick();
            n++;
        end while (fs2 !== 1'b1 && n < 1100);
        total++;
        if (fs2 !== 1'b1) begin
            bad++;
            $display("FAIL wait_fs2: frame_start=%b after %0d cycles, want 1", fs2, n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b0;
        repeat (3) tick();
        total += 6;
        if (cath1 !== 8'hFF) begin bad++; $display("FAIL rst_cath: got %h want FF", cath1); end
        if (an1 !== 8'h00) begin bad++; $display("FAIL rst_anode: got %h want 00", an1); end
        if (lif1.frame_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", lif1.frame_ready); end
        if (fs1 !== 1'b0) begin bad++; $display("FAIL rst_fs: got %b want 0", fs1); end
        if (cath2 !== 8'hFF) begin bad++; $display("FAIL rst_cath2: got %h want FF", cath2); end
        if (an2 !== 8'h00) begin bad++; $display("FAIL rst_anode2: got %h want 00", an2); end
        reset = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            e = 8'h80 >> (k / 8);
            e = ~e;
            total += 3;
            if (cath1 !== e) begin bad++; $display("FAIL walk_cath k=%0d: got %h want %h", k, cath1, e); end
            if (an1 !== 8'h00) begin bad++; $display("FAIL walk_anode k=%0d: got %h want 00", k, an1); end
            if (fs1 !== (k == 0)) begin bad++; $display("FAIL walk_fs k=%0d: got %b want %b", k, fs1, (k == 0)); end
        end
        tick();
        total++;
        if (fs1 !== 1'b1) begin bad++; $display("FAIL walk_period: fs got %b want 1", fs1); end
    endtask

    task automatic test_pixel();
        logic [7:0] e;
        logic [7:0] ea;
        repeat (3) tick();
        lif1.frame_in = 64'h81;
        lif1.frame_valid = 1'b1;
        tick();
        lif1.frame_valid = 1'b0;
        total++;
        if (lif1.frame_ready !== 1'b0) begin bad++; $display("FAIL pix_ready: got %b want 0", lif1.frame_ready); end
        wait_fs1();
        total += 2;
        if (cath1 !== 8'h7F) begin bad++; $display("FAIL pix_cath0: got %h want 7F", cath1); end
        if (an1 !== 8'h80) begin bad++; $display("FAIL pix_anode0: got %h want 80", an1); end
        for (int k = 1; k < 64; k++) begin
            tick();
            ea = (k == 7) ? 8'h01 : 8'h00;
            e = 8'h80 >> (k / 8);
            e = ~e;
            total += 2;
            if (an1 !== ea) begin bad++; $display("FAIL pix_anode k=%0d: got %h want %h", k, an1, ea); end
            if (cath1 !== e) begin bad++; $display("FAIL pix_cath k=%0d: got %h want %h", k, cath1, e); end
        end
        tick();
        total += 2;
        if (fs1 !== 1'b1) begin bad++; $display("FAIL pix_period: fs got %b want 1", fs1); end
        if (an1 !== 8'h80) begin bad++; $display("FAIL pix_wrap: got %h want 80", an1); end
    endtask

    task automatic test_row_mode();
        logic [7:0] pat [8];
        logic [63:0] f;
        logic [7:0] e;
        pat = '{8'h24, 8'h5A, 8'h81, 8'h42, 8'h24, 8'h18, 8'h7E, 8'h81};
        for (int r = 0; r < 8; r++) f[r*8 +: 8] = pat[r];
        repeat (2) tick();
        row_mode = 1'b1;
        lif1.frame_in = f;
        lif1.frame_valid = 1'b1;
        tick();
        lif1.frame_valid = 1'b0;
        wait_fs1();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            e = 8'h80 >> k;
            e = ~e;
            total += 3;
            if (an1 !== pat[k]) begin bad++; $display("FAIL row_anode k=%0d: got %h want %h", k, an1, pat[k]); end
            if (cath1 !== e) begin bad++; $display("FAIL row_cath k=%0d: got %h want %h", k, cath1, e); end
            if (fs1 !== (k == 0)) begin bad++; $display("FAIL row_fs k=%0d: got %b want %b", k, fs1, (k == 0)); end
        end
        tick();
        total++;
        if (fs1 !== 1'b1) begin bad++; $display("FAIL row_len: fs got %b want 1", fs1); end
    endtask

    task automatic test_double_buffer();
        row_mode = 1'b0;
        wait_fs1();
        lif1.frame_in = 64'h80;
        lif1.frame_valid = 1'b1;
        tick();
        total++;
        if (lif1.frame_ready !== 1'b0) begin bad++; $display("FAIL db_readyA: got %b want 0", lif1.frame_ready); end
        lif1.frame_in = 64'h01;
        for (int k = 2; k <= 4; k++) begin
            tick();
            total++;
            if (lif1.frame_ready !== 1'b0) begin bad++; $display("FAIL db_readyB k=%0d: got %b want 0", k, lif1.frame_ready); end
        end
        lif1.frame_valid = 1'b0;
        repeat (58) tick();
        total++;
        if (lif1.frame_ready !== 1'b0) begin bad++; $display("FAIL db_ready62: got %b want 0", lif1.frame_ready); end
        tick();
        total++;
        if (lif1.frame_ready !== 1'b1) begin bad++; $display("FAIL db_ready63: got %b want 1", lif1.frame_ready); end
        tick();
        total += 2;
        if (fs1 !== 1'b1) begin bad++; $display("FAIL db_fs1: got %b want 1", fs1); end
        if (an1 !== 8'h80) begin bad++; $display("FAIL db_A0: got %h want 80", an1); end
        repeat (7) tick();
        total++;
        if (an1 !== 8'h00) begin bad++; $display("FAIL db_A7: got %h want 00", an1); end
        repeat (55) tick();
        lif1.frame_in = 64'h01;
        lif1.frame_valid = 1'b1;
        tick();
        lif1.frame_valid = 1'b0;
        total++;
        if (lif1.frame_ready !== 1'b0) begin bad++; $display("FAIL db_readyC: got %b want 0", lif1.frame_ready); end
        tick();
        total += 2;
        if (fs1 !== 1'b1) begin bad++; $display("FAIL db_fs2: got %b want 1", fs1); end
        if (an1 !== 8'h80) begin bad++; $display("FAIL db_noswap: got %h want 80", an1); end
        repeat (63) tick();
        total++;
        if (lif1.frame_ready !== 1'b1) begin bad++; $display("FAIL db_readyC63: got %b want 1", lif1.frame_ready); end
        tick();
        total += 2;
        if (fs1 !== 1'b1) begin bad++; $display("FAIL db_fs3: got %b want 1", fs1); end
        if (an1 !== 8'h00) begin bad++; $display("FAIL db_C0: got %h want 00", an1); end
        repeat (7) tick();
        total++;
        if (an1 !== 8'h01) begin bad++; $display("FAIL db_C7: got %h want 01", an1); end
    endtask

    task automatic test_pwm();
        logic [7:0] ea;
        logic [7:0] col;
        wait_fs2();
        repeat (2) tick();
        lif2.frame_in = 64'hFF;
        lif2.frame_valid = 1'b1;
        tick();
        lif2.frame_valid = 1'b0;
        brightness2 = 3'd3;
        wait_fs2();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) tick();
            col = 8'h80 >> (k / 8);
            if (k < 16) ea = ((k % 8) < 4) ? col : 8'h00;
            else if (k < 24) ea = col;
            else ea = (k == 24) ? col : 8'h00;
            total += 2;
            if (an2 !== ea) begin bad++; $display("FAIL pwm_anode k=%0d: got %h want %h", k, an2, ea); end
            if (cath2 !== 8'h7F) begin bad++; $display("FAIL pwm_cath k=%0d: got %h want 7F", k, cath2); end
            if (k == 15) brightness2 = 3'd7;
            if (k == 23) brightness2 = 3'd0;
        end
        brightness2 = 3'd7;
        blank2 = 1'b1;
        for (int k = 32; k < 35; k++) begin
            tick();
            total += 2;
            if (an2 !== 8'h00) begin bad++; $display("FAIL blank_anode k=%0d: got %h want 00", k, an2); end
            if (cath2 !== 8'hFF) begin bad++; $display("FAIL blank_cath k=%0d: got %h want FF", k, cath2); end
        end
        blank2 = 1'b0;
        for (int k = 35; k < 41; k++) begin
            tick();
            ea = 8'h80 >> (k / 8);
            total += 2;
            if (an2 !== ea) begin bad++; $display("FAIL unblank_anode k=%0d: got %h want %h", k, an2, ea); end
            if (cath2 !== 8'h7F) begin bad++; $display("FAIL unblank_cath k=%0d: got %h want 7F", k, cath2); end
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0] e;
        wait_fs1();
        repeat (2) tick();
        lif1.frame_in = '1;
        lif1.frame_valid = 1'b1;
        tick();
        lif1.frame_valid = 1'b0;
        total++;
        if (lif1.frame_ready !== 1'b0) begin bad++; $display("FAIL mr_pending: got %b want 0", lif1.frame_ready); end
        repeat (32) tick();
        total++;
        if (cath1 !== 8'hF7) begin bad++; $display("FAIL mr_row4: got %h want F7", cath1); end
        reset = 1'b0;
        #1;
        total += 4;
        if (cath1 !== 8'hFF) begin bad++; $display("FAIL mr_cath: got %h want FF", cath1); end
        if (an1 !== 8'h00) begin bad++; $display("FAIL mr_anode: got %h want 00", an1); end
        if (lif1.frame_ready !== 1'b1) begin bad++; $display("FAIL mr_ready: got %b want 1", lif1.frame_ready); end
        if (fs1 !== 1'b0) begin bad++; $display("FAIL mr_fs: got %b want 0", fs1); end
        #2;
        reset = 1'b1;
        for (int k = 0; k < 128; k++) begin
            tick();
            e = 8'h80 >> ((k % 64) / 8);
            e = ~e;
            total += 4;
            if (an1 !== 8'h00) begin bad++; $display("FAIL mr_dark k=%0d: got %h want 00", k, an1); end
            if (cath1 !== e) begin bad++; $display("FAIL mr_walk k=%0d: got %h want %h", k, cath1, e); end
            if (fs1 !== ((k % 64) == 0)) begin bad++; $display("FAIL mr_fs k=%0d: got %b want %b", k, fs1, ((k % 64) == 0)); end
            if (lif1.frame_ready !== 1'b1) begin bad++; $display("FAIL mr_ready k=%0d: got %b want 1", k, lif1.frame_ready); end
        end
    endtask

    initial begin
        reset = 1'b0;
        row_mode = 1'b0;
        blank = 1'b0;
        brightness = 3'd7;
        row_mode2 = 1'b0;
        blank2 = 1'b0;
        brightness2 = 3'd7;
        lif1.frame_in = '0;
        lif1.frame_valid = 1'b0;
        lif2.frame_in = '0;
        lif2.frame_valid = 1'b0;
        test_reset();
        test_pixel();
        test_row_mode();
        test_double_buffer();
        test_pwm();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
